vote_tally_seq: RTL and testbench
=================================

Name: vote_tally_seq

Overview:
- Sequential, parametrised successor to the team's 3-voter combinational vote counter.
- Accepts a stream of N-voter ballots (one bit per voter, 1 = yes) during an open voting session.
- Per ballot: reports the yes-count as a one-hot vector (bit k set = exactly k yes votes).
- Per session: accumulates yes/no totals and the ballot count, then publishes a final result with majority/tie flags when the session closes.

Parameters:
- N_VOTERS, 8: voters per ballot (vote width); legal range 2..32.
- TOT_W, 16: width of yes_total/no_total; saturating.
- RND_W, 8: width of the ballot (round) counter.
- MAX_ROUNDS, 200: session auto-closes after this many accepted ballots; must be ≤ 2^RND_W-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  open a new session (honoured in IDLE and DONE only).
- vote_valid  in  1  ballot present on vote.
- vote_ready  out  1  block can accept a ballot this cycle.
- vote  in  N_VOTERS  ballot, bit i = voter i's vote.
- close  in  1  request end of session (honoured in OPEN only).
- count_onehot  out  N_VOTERS+1  one-hot yes-count of the last accepted ballot.
- count_valid  out  1  one-cycle pulse, count_onehot updated.
- yes_total  out  TOT_W  accumulated yes votes this session.
- no_total  out  TOT_W  accumulated no votes this session.
- rounds  out  RND_W  accepted ballots this session.
- saturated  out  1  sticky: a total hit 2^TOT_W-1 this session.
- done  out  1  level, high in DONE; results final.
- majority  out  1  valid while done: yes_total > no_total.
- tie  out  1  valid while done: yes_total == no_total.

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - state=IDLE.
  - All outputs 0, including count_onehot=0 (no ballot yet). vote_ready=0.
- Reset asserted mid-session: all tallies are lost immediately; no partial result is published.
- FSM states: IDLE, OPEN, DRAIN, DONE.
  - IDLE: start -> OPEN; totals, rounds and saturated clear on the same edge.
  - OPEN:
    - vote_ready=1.
    - A ballot is accepted when vote_valid & vote_ready.
    - close, or acceptance of ballot number MAX_ROUNDS -> DRAIN.
    - close together with vote_valid: the ballot is accepted, then the block moves to DRAIN.
    - start is ignored.
  - DRAIN: vote_ready=0; stays one cycle so the accumulator stage retires -> DONE.
  - DONE:
    - done=1; majority and tie are registered on entry and held.
    - start -> OPEN with a fresh session; done, majority and tie drop on that edge.
    - close is ignored.
- Pipeline: ballot accepted at edge t.
  - Stage 1 (edge t+1):
    - p = popcount(vote).
    - count_onehot = 1<<p; count_valid pulses.
    - rounds += 1.
  - Stage 2 (edge t+2): yes_total += p; no_total += N_VOTERS-p.
  - Back-to-back ballots every cycle are supported; throughput is 1 ballot/clk.
- Arithmetic:
  - p is $clog2(N_VOTERS+1) bits wide, zero-extended to TOT_W before the add.
  - Each total saturates at 2^TOT_W-1 independently. The first saturating add sets saturated, which stays set until the next start.
  - rounds never wraps because of the MAX_ROUNDS auto-close.
- Empty session (close with no ballots): totals=0, majority=0, tie=1.
- count_onehot holds its value between ballots; it clears only on reset, not on start.
- Invariant: count_onehot is either 0 or has exactly one bit set.

Decomposition:
- vote_pkg:
  - state enum typedef (IDLE/OPEN/DRAIN/DONE).
  - localparam function for popcount width, $clog2(N+1).
  - saturating-add function, sat_add.
- Sub-module popcount_onehot:
  - Combinational; parameter N.
  - Input vector -> popcount and one-hot count.
  - The N=3 instance must match the legacy counter's truth table.
- Top: FSM, two pipeline registers, accumulators and result flags.

Test Plan:
- Reset then start; ballots 8'b0000_0000, 8'b1111_1111, 8'b0000_0111 back-to-back, then close:
  - count_onehot is 9'h001, 9'h100, 9'h008 on consecutive cycles.
  - Final yes=11, no=13, rounds=3.
  - done=1, majority=0, tie=0.
- N_VOTERS=3: sweep all 8 ballots -> count_onehot matches the legacy mapping (000->0001, 011->0100, 111->1000).
- close asserted in the same cycle as vote 8'hF0:
  - The ballot is counted (yes=4, rounds=1).
  - vote_ready drops the next cycle; done asserts 2 cycles after close.
- TOT_W=4: five ballots of 8'hFF:
  - yes_total saturates at 15; saturated=1; no_total=0.
  - Next start clears saturated and the totals.
- MAX_ROUNDS=4, vote_valid held high -> exactly 4 ballots accepted, then auto DRAIN -> DONE with no close.
- rst asserted mid-session (rounds=2):
  - All outputs 0 asynchronously, before the next clk edge; state=IDLE.
  - A ballot presented after release is not accepted until start.

Source files
------------

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state type and arithmetic helpers for the vote tally block
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width needed to hold a yes-count of 0..n.
  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Add two unsigned values and clamp the result at max_v (which is all-ones in the caller's width).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) begin
      return max_v;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/vote_tally_seq_popcount.sv
// rtl/vote_tally_seq_popcount.sv - combinational ballot popcount with one-hot count output
module popcount_onehot
  import vote_pkg::*;
#(
  parameter  int N  = 8,
  localparam int PW = pc_width(N)
) (
  input  logic [N-1:0]  vec,
  output logic [PW-1:0] count,
  output logic [N:0]    onehot
);

  localparam int OW = N + 1;

  // Count the set bits, then turn the count into a single bit at position count.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + PW'(vec[i]);
    end
    onehot = OW'(1) << count;
  end

endmodule

// File: rtl/vote_tally_seq.sv
// rtl/vote_tally_seq.sv - session-based ballot tally with per-ballot one-hot count and final result
module vote_tally_seq
  import vote_pkg::*;
#(
  parameter int N_VOTERS   = 8,
  parameter int TOT_W      = 16,
  parameter int RND_W      = 8,
  parameter int MAX_ROUNDS = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                vote_valid,
  output logic                vote_ready,
  input  logic [N_VOTERS-1:0] vote,
  input  logic                close,
  output logic [N_VOTERS:0]   count_onehot,
  output logic                count_valid,
  output logic [TOT_W-1:0]    yes_total,
  output logic [TOT_W-1:0]    no_total,
  output logic [RND_W-1:0]    rounds,
  output logic                saturated,
  output logic                done,
  output logic                majority,
  output logic                tie
);

  localparam int               PW        = pc_width(N_VOTERS);
  localparam logic [31:0]      TOT_MAX32 = 32'({TOT_W{1'b1}});
  localparam logic [TOT_W-1:0] TOT_MAX   = '1;
  localparam logic [PW-1:0]    N_P       = PW'(N_VOTERS);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(MAX_ROUNDS - 1);

  state_e              state_q, state_d;
  logic [N_VOTERS:0]   count_onehot_q, count_onehot_d;
  logic                count_valid_q, count_valid_d;
  logic [PW-1:0]       p_q, p_d;
  logic [RND_W-1:0]    rounds_q, rounds_d;
  logic [TOT_W-1:0]    yes_q, yes_d, no_q, no_d;
  logic [TOT_W-1:0]    yes_sum, no_sum;
  logic                sat_q, sat_d;
  logic                majority_q, majority_d;
  logic                tie_q, tie_d;

  logic [PW-1:0]       pc_count;
  logic [N_VOTERS:0]   pc_onehot;
  logic                accept;
  logic                session_clr;

  popcount_onehot #(.N(N_VOTERS)) u_popcount (
    .vec    (vote),
    .count  (pc_count),
    .onehot (pc_onehot)
  );

  assign accept      = vote_valid && (state_q == OPEN);
  assign session_clr = start && ((state_q == IDLE) || (state_q == DONE));

  // Session FSM: the final ballot or a close request sends OPEN through one drain cycle to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = OPEN;
      OPEN:    if (close || (accept && (rounds_q == LAST_RND))) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start) state_d = OPEN;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 captures the ballot count; stage 2 folds it into the saturating totals.
  always_comb begin
    count_onehot_d = accept ? pc_onehot : count_onehot_q;
    count_valid_d  = accept;
    p_d            = accept ? pc_count : p_q;
    rounds_d       = rounds_q;
    yes_d          = yes_q;
    no_d           = no_q;
    sat_d          = sat_q;
    majority_d     = majority_q;
    tie_d          = tie_q;
    yes_sum        = TOT_W'(sat_add(32'(yes_q), 32'(p_q), TOT_MAX32));
    no_sum         = TOT_W'(sat_add(32'(no_q), 32'(N_P - p_q), TOT_MAX32));

    if (session_clr) begin
      rounds_d   = '0;
      yes_d      = '0;
      no_d       = '0;
      sat_d      = 1'b0;
      majority_d = 1'b0;
      tie_d      = 1'b0;
    end else begin
      if (accept) begin
        rounds_d = rounds_q + RND_W'(1);
      end
      if (count_valid_q) begin
        yes_d = yes_sum;
        no_d  = no_sum;
        if ((yes_sum == TOT_MAX) || (no_sum == TOT_MAX)) begin
          sat_d = 1'b1;
        end
      end
      // The last accumulate retires on the same edge DONE is entered, so judge the next totals.
      if (state_q == DRAIN) begin
        majority_d = (yes_d > no_d);
        tie_d      = (yes_d == no_d);
      end
    end
  end

  // All state registers; reset drops every tally at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      count_onehot_q <= '0;
      count_valid_q  <= 1'b0;
      p_q            <= '0;
      rounds_q       <= '0;
      yes_q          <= '0;
      no_q           <= '0;
      sat_q          <= 1'b0;
      majority_q     <= 1'b0;
      tie_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_onehot_q <= count_onehot_d;
      count_valid_q  <= count_valid_d;
      p_q            <= p_d;
      rounds_q       <= rounds_d;
      yes_q          <= yes_d;
      no_q           <= no_d;
      sat_q          <= sat_d;
      majority_q     <= majority_d;
      tie_q          <= tie_d;
    end
  end

  assign vote_ready   = (state_q == OPEN);
  assign done         = (state_q == DONE);
  assign count_onehot = count_onehot_q;
  assign count_valid  = count_valid_q;
  assign yes_total    = yes_q;
  assign no_total     = no_q;
  assign rounds       = rounds_q;
  assign saturated    = sat_q;
  assign majority     = majority_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_vote_tally_seq.sv
// tb/tb_vote_tally_seq.sv - directed self-checking bench for vote_tally_seq
module tb_vote_tally_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Instance A: default parameters
  logic a_start, a_valid, a_close, a_ready, a_cv, a_sat, a_done, a_maj, a_tie;
  logic [7:0]  a_vote;
  logic [8:0]  a_oh;
  logic [15:0] a_yes, a_no;
  logic [7:0]  a_rnd;

  // Instance B: three voters (legacy-compatible count)
  logic b_start, b_valid, b_close, b_ready, b_cv, b_sat, b_done, b_maj, b_tie;
  logic [2:0]  b_vote;
  logic [3:0]  b_oh;
  logic [15:0] b_yes, b_no;
  logic [7:0]  b_rnd;

  // Instance C: 4-bit totals for saturation
  logic c_start, c_valid, c_close, c_ready, c_cv, c_sat, c_done, c_maj, c_tie;
  logic [7:0]  c_vote;
  logic [8:0]  c_oh;
  logic [3:0]  c_yes, c_no;
  logic [7:0]  c_rnd;

  // Instance D: auto-close after 4 ballots
  logic d_start, d_valid, d_close, d_ready, d_cv, d_sat, d_done, d_maj, d_tie;
  logic [7:0]  d_vote;
  logic [8:0]  d_oh;
  logic [15:0] d_yes, d_no;
  logic [7:0]  d_rnd;

  vote_tally_seq u_a (
    .clk(clk), .rst(rst), .start(a_start), .vote_valid(a_valid), .vote_ready(a_ready),
    .vote(a_vote), .close(a_close), .count_onehot(a_oh), .count_valid(a_cv),
    .yes_total(a_yes), .no_total(a_no), .rounds(a_rnd), .saturated(a_sat),
    .done(a_done), .majority(a_maj), .tie(a_tie)
  );

  vote_tally_seq #(.N_VOTERS(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .vote_valid(b_valid), .vote_ready(b_ready),
    .vote(b_vote), .close(b_close), .count_onehot(b_oh), .count_valid(b_cv),
    .yes_total(b_yes), .no_total(b_no), .rounds(b_rnd), .saturated(b_sat),
    .done(b_done), .majority(b_maj), .tie(b_tie)
  );

  vote_tally_seq #(.TOT_W(4)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .vote_valid(c_valid), .vote_ready(c_ready),
    .vote(c_vote), .close(c_close), .count_onehot(c_oh), .count_valid(c_cv),
    .yes_total(c_yes), .no_total(c_no), .rounds(c_rnd), .saturated(c_sat),
    .done(c_done), .majority(c_maj), .tie(c_tie)
  );

  vote_tally_seq #(.MAX_ROUNDS(4)) u_d (
    .clk(clk), .rst(rst), .start(d_start), .vote_valid(d_valid), .vote_ready(d_ready),
    .vote(d_vote), .close(d_close), .count_onehot(d_oh), .count_valid(d_cv),
    .yes_total(d_yes), .no_total(d_no), .rounds(d_rnd), .saturated(d_sat),
    .done(d_done), .majority(d_maj), .tie(d_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++; if (a_oh !== 9'h000) begin errors++; $display("FAIL rst_onehot got %0h exp 0", a_oh); end
    checks++; if ({a_ready, a_cv, a_sat, a_done, a_maj, a_tie} !== 6'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 000000", {a_ready, a_cv, a_sat, a_done, a_maj, a_tie}); end
    checks++; if ({a_yes, a_no, a_rnd} !== 40'h0) begin
      errors++; $display("FAIL rst_totals got %0h exp 0", {a_yes, a_no, a_rnd}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", a_ready); end
    a_valid = 1'b1; a_vote = 8'h00;
    @(negedge clk);
    checks++; if (a_oh !== 9'h001 || a_cv !== 1'b1) begin
      errors++; $display("FAIL basic_oh0 got %0h/%b exp 001/1", a_oh, a_cv); end
    a_vote = 8'hFF;
    @(negedge clk);
    checks++; if (a_oh !== 9'h100) begin errors++; $display("FAIL basic_oh1 got %0h exp 100", a_oh); end
    a_vote = 8'h07;
    @(negedge clk);
    checks++; if (a_oh !== 9'h008) begin errors++; $display("FAIL basic_oh2 got %0h exp 008", a_oh); end
    a_valid = 1'b0; a_close = 1'b1;
    @(negedge clk) a_close = 1'b0;
    checks++; if (a_ready !== 1'b0 || a_cv !== 1'b0 || a_oh !== 9'h008) begin
      errors++; $display("FAIL basic_drain got rdy=%b cv=%b oh=%0h exp 0/0/008", a_ready, a_cv, a_oh); end
    @(negedge clk);
    checks++; if (a_yes !== 16'd11 || a_no !== 16'd13 || a_rnd !== 8'd3) begin
      errors++; $display("FAIL basic_totals got %0d/%0d/%0d exp 11/13/3", a_yes, a_no, a_rnd); end
    checks++; if ({a_done, a_maj, a_tie} !== 3'b100) begin
      errors++; $display("FAIL basic_result got %b exp 100", {a_done, a_maj, a_tie}); end
  endtask

  task automatic test_close_with_vote();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    checks++; if (a_done !== 1'b0 || a_yes !== 16'd0 || a_rnd !== 8'd0) begin
      errors++; $display("FAIL restart_clear got %b/%0d/%0d exp 0/0/0", a_done, a_yes, a_rnd); end
    a_valid = 1'b1; a_vote = 8'hF0; a_close = 1'b1;
    @(negedge clk) a_valid = 1'b0; a_close = 1'b0;
    checks++; if (a_ready !== 1'b0 || a_rnd !== 8'd1 || a_oh !== 9'h010 || a_done !== 1'b0) begin
      errors++; $display("FAIL close_same got rdy=%b rnd=%0d oh=%0h done=%b exp 0/1/010/0", a_ready, a_rnd, a_oh, a_done); end
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_yes !== 16'd4 || a_no !== 16'd4 || a_tie !== 1'b1 || a_maj !== 1'b0) begin
      errors++; $display("FAIL close_result got d=%b y=%0d n=%0d t=%b m=%b exp 1/4/4/1/0", a_done, a_yes, a_no, a_tie, a_maj); end
  endtask

  task automatic test_majority_and_empty();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0; a_valid = 1'b1; a_vote = 8'hFF; a_close = 1'b1;
    @(negedge clk) a_valid = 1'b0; a_close = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_yes !== 16'd8 || a_maj !== 1'b1 || a_tie !== 1'b0) begin
      errors++; $display("FAIL majority got d=%b y=%0d m=%b t=%b exp 1/8/1/0", a_done, a_yes, a_maj, a_tie); end
    a_start = 1'b1;
    @(negedge clk) a_start = 1'b0; a_close = 1'b1;
    @(negedge clk) a_close = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_yes !== 16'd0 || a_no !== 16'd0 || a_rnd !== 8'd0 || a_tie !== 1'b1 || a_maj !== 1'b0) begin
      errors++; $display("FAIL empty got d=%b y=%0d n=%0d r=%0d t=%b m=%b exp 1/0/0/0/1/0", a_done, a_yes, a_no, a_rnd, a_tie, a_maj); end
    checks++; if (a_oh !== 9'h100) begin errors++; $display("FAIL oh_hold got %0h exp 100", a_oh); end
  endtask

  task automatic test_legacy_n3();
    logic [3:0] exp_oh [8];
    exp_oh = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++; if (b_oh !== exp_oh[i-1]) begin
          errors++; $display("FAIL legacy_%0d got %b exp %b", i - 1, b_oh, exp_oh[i-1]); end
      end
      if (i < 8) begin
        b_valid = 1'b1; b_vote = 3'(i);
      end else begin
        b_valid = 1'b0; b_close = 1'b1;
      end
      @(negedge clk);
    end
    b_close = 1'b0;
    @(negedge clk);
    checks++; if (b_done !== 1'b1 || b_yes !== 16'd12 || b_no !== 16'd12 || b_rnd !== 8'd8 || b_tie !== 1'b1) begin
      errors++; $display("FAIL legacy_totals got d=%b y=%0d n=%0d r=%0d t=%b exp 1/12/12/8/1", b_done, b_yes, b_no, b_rnd, b_tie); end
  endtask

  task automatic test_saturation();
    @(negedge clk) c_start = 1'b1;
    @(negedge clk) c_start = 1'b0; c_valid = 1'b1; c_vote = 8'hFF;
    repeat (5) @(negedge clk);
    c_valid = 1'b0;
    @(negedge clk);
    checks++; if (c_yes !== 4'd15 || c_no !== 4'd0 || c_sat !== 1'b1 || c_rnd !== 8'd5) begin
      errors++; $display("FAIL sat_totals got y=%0d n=%0d s=%b r=%0d exp 15/0/1/5", c_yes, c_no, c_sat, c_rnd); end
    c_close = 1'b1;
    @(negedge clk) c_close = 1'b0;
    @(negedge clk);
    checks++; if (c_done !== 1'b1 || c_maj !== 1'b1 || c_sat !== 1'b1) begin
      errors++; $display("FAIL sat_done got d=%b m=%b s=%b exp 1/1/1", c_done, c_maj, c_sat); end
    c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    checks++; if (c_sat !== 1'b0 || c_yes !== 4'd0 || c_no !== 4'd0 || c_rnd !== 8'd0 || c_done !== 1'b0) begin
      errors++; $display("FAIL sat_clear got s=%b y=%0d n=%0d r=%0d d=%b exp 0/0/0/0/0", c_sat, c_yes, c_no, c_rnd, c_done); end
  endtask

  task automatic test_auto_close();
    int pulses;
    pulses = 0;
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0; d_valid = 1'b1; d_vote = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_cv === 1'b1) pulses++;
    end
    d_valid = 1'b0;
    checks++; if (pulses != 4 || d_rnd !== 8'd4) begin
      errors++; $display("FAIL auto_count got pulses=%0d r=%0d exp 4/4", pulses, d_rnd); end
    checks++; if (d_done !== 1'b1 || d_ready !== 1'b0 || d_yes !== 16'd4 || d_no !== 16'd28) begin
      errors++; $display("FAIL auto_done got d=%b rdy=%b y=%0d n=%0d exp 1/0/4/28", d_done, d_ready, d_yes, d_no); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0; a_valid = 1'b1; a_vote = 8'hFF;
    @(negedge clk) a_vote = 8'h03;
    @(negedge clk) a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_rnd !== 8'd2 || a_yes !== 16'd10) begin
      errors++; $display("FAIL mid_pre got r=%0d y=%0d exp 2/10", a_rnd, a_yes); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_ready, a_cv, a_sat, a_done, a_maj, a_tie} !== 6'b0 || a_oh !== 9'h000 ||
                  {a_yes, a_no, a_rnd} !== 40'h0) begin
      errors++; $display("FAIL mid_async got flags=%b oh=%0h tot=%0h exp 0/0/0",
                         {a_ready, a_cv, a_sat, a_done, a_maj, a_tie}, a_oh, {a_yes, a_no, a_rnd}); end
    @(negedge clk) rst = 1'b0; a_valid = 1'b1; a_vote = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_cv !== 1'b0 || a_rnd !== 8'd0 || a_ready !== 1'b0) begin
        errors++; $display("FAIL mid_idle_%0d got cv=%b r=%0d rdy=%b exp 0/0/0", i, a_cv, a_rnd, a_ready); end
    end
    a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    checks++; if (a_rnd !== 8'd0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL mid_start got r=%0d rdy=%b exp 0/1", a_rnd, a_ready); end
    @(negedge clk) a_valid = 1'b0;
    checks++; if (a_rnd !== 8'd1 || a_oh !== 9'h100) begin
      errors++; $display("FAIL mid_accept got r=%0d oh=%0h exp 1/100", a_rnd, a_oh); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_close = 0; a_vote = '0;
    b_start = 0; b_valid = 0; b_close = 0; b_vote = '0;
    c_start = 0; c_valid = 0; c_close = 0; c_vote = '0;
    d_start = 0; d_valid = 0; d_close = 0; d_vote = '0;
    test_reset();
    test_basic();
    test_close_with_vote();
    test_majority_and_empty();
    test_legacy_n3();
    test_saturation();
    test_auto_close();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
